// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, h/v counters, sync/active decode,
// line/frame markers, pause and frame counter. Define VGA_PIX_ADDR_EN to add the pix_addr output.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic          pix_tick,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
`ifdef VGA_PIX_ADDR_EN
  ,
  output logic [19:0]   pix_addr
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div, div_n;
  logic [CW-1:0] hc_n, vc_n;
  logic          tick, h_wrap, v_wrap, line_n, frame_n, hs_on, vs_on, act_n;
  logic          ls_q, fs_q;

  always_comb begin
    tick    = en & ~clr & (div == DIV_MAX);
    h_wrap  = (hc == H_LAST);
    v_wrap  = (vc == V_LAST);
    div_n   = div;
    hc_n    = hc;
    vc_n    = vc;
    if (en) div_n = tick ? '0 : div + DW'(1);
    if (tick) begin
      if (h_wrap) begin
        hc_n = '0;
        vc_n = v_wrap ? '0 : vc + CW'(1);
      end else begin
        hc_n = hc + CW'(1);
      end
    end
    line_n  = tick & h_wrap;
    frame_n = line_n & v_wrap;
    // Decode from the next-state counters so the registered levels line up with hc/vc.
    hs_on   = (hc_n >= HS_FIRST) && (hc_n <= HS_LAST);
    vs_on   = (vc_n >= VS_FIRST) && (vc_n <= VS_LAST);
    act_n   = (hc_n < H_ACT) && (vc_n < V_ACT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div       <= '0;
      hc        <= '0;
      vc        <= '0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      active    <= 1'b1;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      div    <= div_n;
      hc     <= hc_n;
      vc     <= vc_n;
      hsync  <= hs_on ? HS_POL : ~HS_POL;
      vsync  <= vs_on ? VS_POL : ~VS_POL;
      active <= act_n;
      ls_q   <= line_n;
      fs_q   <= frame_n;
      if (frame_n) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef VGA_PIX_ADDR_EN
  // Running address: bumped once per visible pixel, so it parks at the next line's base in blanking.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)               pix_addr <= '0;
    else if (frame_n)      pix_addr <= '0;
    else if (tick && active) pix_addr <= pix_addr + 20'd1;
  end
`endif

  assign pix_tick    = tick;
  assign line_start  = ls_q & en;
  assign frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small raster plus a default-size instance, checked
// against a position model derived from the count of enabled clocks since reset.
module tb_vga_timing_gen;
  localparam int CD = 2, HA = 8, HFP = 2, HS = 3, HT = 14, VA = 4, VFP = 1, VS = 2, VT = 8;

  logic clk = 1'b0;
  logic clr, en, clr_d, en_d;
  always #5 clk = ~clk;

  logic       pix_tick, hsync, vsync, active, line_start, frame_start;
  logic [9:0] hc, vc;
  logic [15:0] frame_cnt;
  logic       p_pix_tick, p_hsync, p_vsync, p_active, p_line_start, p_frame_start;
  logic [9:0] p_hc, p_vc;
  logic [15:0] p_frame_cnt;
  logic       d_pix_tick, d_hsync, d_vsync, d_active, d_line_start, d_frame_start;
  logic [9:0] d_hc, d_vc;
  logic [15:0] d_frame_cnt;
`ifdef VGA_PIX_ADDR_EN
  logic [19:0] pix_addr, p_pix_addr, d_pix_addr;
`endif

  vga_timing_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(1),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(1),
                   .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)) dut (
    .clk(clk), .clr(clr), .en(en), .pix_tick(pix_tick), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .active(active), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
`ifdef VGA_PIX_ADDR_EN
    , .pix_addr(pix_addr)
`endif
  );

  vga_timing_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(1),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)) dut_p (
    .clk(clk), .clr(clr), .en(en), .pix_tick(p_pix_tick), .hc(p_hc), .vc(p_vc),
    .hsync(p_hsync), .vsync(p_vsync), .active(p_active), .line_start(p_line_start),
    .frame_start(p_frame_start), .frame_cnt(p_frame_cnt)
`ifdef VGA_PIX_ADDR_EN
    , .pix_addr(p_pix_addr)
`endif
  );

  vga_timing_gen dut_d (
    .clk(clk), .clr(clr_d), .en(en_d), .pix_tick(d_pix_tick), .hc(d_hc), .vc(d_vc),
    .hsync(d_hsync), .vsync(d_vsync), .active(d_active), .line_start(d_line_start),
    .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
`ifdef VGA_PIX_ADDR_EN
    , .pix_addr(d_pix_addr)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state: enabled clock edges since reset, and whether the last edge completed a pixel.
  int e;
  bit lt;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      e  <= 0;
      lt <= 1'b0;
    end else if (en) begin
      e  <= e + 1;
      lt <= ((e + 1) % CD == 0);
    end else begin
      lt <= 1'b0;
    end
  end

  function automatic int m_hc();  return (e / CD) % HT;               endfunction
  function automatic int m_vc();  return ((e / CD) % (HT * VT)) / HT; endfunction
  function automatic int m_fc();  return ((e / CD) / (HT * VT)) % 65536; endfunction
  function automatic bit m_pix(); return en && !clr && (e % CD == CD - 1); endfunction
  function automatic bit m_ls();  return en && lt && (m_hc() == 0);   endfunction
  function automatic bit m_fs();  return m_ls() && (m_vc() == 0);     endfunction
  function automatic bit m_hs_on(); return m_hc() >= HA + HFP && m_hc() < HA + HFP + HS; endfunction
  function automatic bit m_vs_on(); return m_vc() >= VA + VFP && m_vc() < VA + VFP + VS; endfunction
  function automatic bit m_act(); return m_hc() < HA && m_vc() < VA;  endfunction
  function automatic int m_addr();
    if (m_vc() < VA) return m_vc() * HA + ((m_hc() < HA) ? m_hc() : HA);
    return VA * HA;
  endfunction

  task automatic test_reset();
    clr = 1'b1; en = 1'b1; clr_d = 1'b1; en_d = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (hc !== 10'd0 || vc !== 10'd0) begin errors++;
      $display("FAIL reset_pos got hc=%0d vc=%0d exp 0 0", hc, vc); end
    checks++; if (pix_tick !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) begin errors++;
      $display("FAIL reset_pulses got %b%b%b exp 000", pix_tick, line_start, frame_start); end
    checks++; if (frame_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_fc got %0d exp 0", frame_cnt); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || active !== 1'b1) begin errors++;
      $display("FAIL reset_levels got hs=%b vs=%b act=%b exp 1 1 1", hsync, vsync, active); end
    checks++; if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin errors++;
      $display("FAIL reset_pol got hs=%b vs=%b exp 0 0", p_hsync, p_vsync); end
    checks++; if (d_hsync !== 1'b1 || d_hc !== 10'd0 || d_active !== 1'b1) begin errors++;
      $display("FAIL reset_default got hs=%b hc=%0d act=%b exp 1 0 1", d_hsync, d_hc, d_active); end
`ifdef VGA_PIX_ADDR_EN
    checks++; if (pix_addr !== 20'd0) begin errors++;
      $display("FAIL reset_addr got %0d exp 0", pix_addr); end
`endif
    clr = 1'b0;
  endtask

  task automatic test_raster();
    int n_pix = 0, n_ls = 0, n_fs = 0, n_hs = 0, n_vs = 0, n_act = 0, first_fs = -1;
    for (int k = 1; k <= 3 * CD * HT * VT; k++) begin
      @(negedge clk);
      checks++; if (hc !== 10'(m_hc()) || vc !== 10'(m_vc())) begin errors++;
        $display("FAIL raster_pos k=%0d got %0d,%0d exp %0d,%0d", k, hc, vc, m_hc(), m_vc()); end
      n_pix += int'(pix_tick); n_ls += int'(line_start); n_fs += int'(frame_start);
      n_hs  += int'(hsync == 1'b0); n_vs += int'(vsync == 1'b0);
      n_act += int'(pix_tick && active);
      if (frame_start && first_fs < 0) first_fs = k;
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL raster_fc got %0d exp 3", frame_cnt); end
    checks++; if (n_pix != 3 * HT * VT) begin errors++; $display("FAIL raster_ticks got %0d exp %0d", n_pix, 3 * HT * VT); end
    checks++; if (n_ls != 3 * VT) begin errors++; $display("FAIL raster_lines got %0d exp %0d", n_ls, 3 * VT); end
    checks++; if (n_fs != 3) begin errors++; $display("FAIL raster_frames got %0d exp 3", n_fs); end
    checks++; if (first_fs != CD * HT * VT) begin errors++; $display("FAIL raster_fs_time got %0d exp %0d", first_fs, CD * HT * VT); end
    checks++; if (n_hs != 3 * VT * HS * CD) begin errors++; $display("FAIL raster_hsync got %0d exp %0d", n_hs, 3 * VT * HS * CD); end
    checks++; if (n_vs != 3 * VS * HT * CD) begin errors++; $display("FAIL raster_vsync got %0d exp %0d", n_vs, 3 * VS * HT * CD); end
    checks++; if (n_act != 3 * HA * VA) begin errors++; $display("FAIL raster_active got %0d exp %0d", n_act, 3 * HA * VA); end
  endtask

  task automatic test_pause();
    int n = 0;
    logic [15:0] fc0;
    logic hs0;
    while (!(m_hc() == 5 && m_vc() == 2) && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n >= 1000) begin errors++; $display("FAIL pause_wait got %0d exp <1000", n); end
    fc0 = 16'(m_fc()); hs0 = !m_hs_on();
    en = 1'b0;
    repeat (50) begin
      @(negedge clk);
      checks++; if (hc !== 10'd5 || vc !== 10'd2 || frame_cnt !== fc0) begin errors++;
        $display("FAIL pause_hold got %0d,%0d,%0d exp 5,2,%0d", hc, vc, frame_cnt, fc0); end
      checks++; if (pix_tick !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0 || hsync !== hs0) begin errors++;
        $display("FAIL pause_outs got %b%b%b hs=%b exp 000 hs=%b", pix_tick, line_start, frame_start, hsync, hs0); end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (pix_tick !== 1'b1 || hc !== 10'd5) begin errors++;
      $display("FAIL resume_phase got tick=%b hc=%0d exp 1 5", pix_tick, hc); end
    @(negedge clk);
    checks++; if (pix_tick !== 1'b0 || hc !== 10'd6) begin errors++;
      $display("FAIL resume_hc got tick=%b hc=%0d exp 0 6", pix_tick, hc); end
  endtask

  task automatic test_midreset();
    int n = 0;
    while (m_vc() != 6 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n >= 1000) begin errors++; $display("FAIL midreset_wait got %0d exp <1000", n); end
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checks++; if (hc !== 10'd0 || vc !== 10'd0 || frame_cnt !== 16'd0) begin errors++;
      $display("FAIL midreset_pos got %0d,%0d,%0d exp 0,0,0", hc, vc, frame_cnt); end
    checks++; if (active !== 1'b1 || frame_start !== 1'b0 || line_start !== 1'b0 || vsync !== 1'b1) begin errors++;
      $display("FAIL midreset_levels got act=%b fs=%b ls=%b vs=%b exp 1 0 0 1", active, frame_start, line_start, vsync); end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++; if (frame_start !== 1'b0 || hc !== 10'd0 || pix_tick !== m_pix()) begin errors++;
      $display("FAIL midreset_after got fs=%b hc=%0d tick=%b exp 0 0 %b", frame_start, hc, pix_tick, m_pix()); end
  endtask

  task automatic test_random_pause();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++; if (hc !== 10'(m_hc()) || vc !== 10'(m_vc()) || frame_cnt !== 16'(m_fc())) begin errors++;
        $display("FAIL rnd_count k=%0d got %0d,%0d,%0d exp %0d,%0d,%0d", k, hc, vc, frame_cnt, m_hc(), m_vc(), m_fc()); end
      checks++; if (pix_tick !== m_pix() || line_start !== m_ls() || frame_start !== m_fs()) begin errors++;
        $display("FAIL rnd_pulse k=%0d got %b%b%b exp %b%b%b", k, pix_tick, line_start, frame_start, m_pix(), m_ls(), m_fs()); end
      checks++; if (hsync !== !m_hs_on() || vsync !== !m_vs_on() || active !== m_act()) begin errors++;
        $display("FAIL rnd_level k=%0d got %b%b%b exp %b%b%b", k, hsync, vsync, active, !m_hs_on(), !m_vs_on(), m_act()); end
      checks++; if (p_hsync !== m_hs_on() || p_vsync !== m_vs_on()) begin errors++;
        $display("FAIL rnd_pol k=%0d got %b%b exp %b%b", k, p_hsync, p_vsync, m_hs_on(), m_vs_on()); end
`ifdef VGA_PIX_ADDR_EN
      checks++; if (pix_addr !== 20'(m_addr())) begin errors++;
        $display("FAIL rnd_addr k=%0d got %0d exp %0d", k, pix_addr, m_addr()); end
`endif
      en = ($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
  endtask

  task automatic test_defaults();
    int n_hs = 0, n_ls = 0, n_pix = 0, ls_at = -1;
    @(negedge clk);
    clr_d = 1'b0;
    for (int k = 1; k <= 3200; k++) begin
      @(negedge clk);
      n_hs  += int'(d_hsync == 1'b0);
      n_pix += int'(d_pix_tick);
      if (d_line_start) begin n_ls++; ls_at = k; end
      if (k == 3200) begin
        checks++; if (d_hc !== 10'd0 || d_vc !== 10'd1) begin errors++;
          $display("FAIL dflt_wrap got %0d,%0d exp 0,1", d_hc, d_vc); end
`ifdef VGA_PIX_ADDR_EN
        checks++; if (d_pix_addr !== 20'd640) begin errors++;
          $display("FAIL dflt_addr got %0d exp 640", d_pix_addr); end
`endif
      end
    end
    checks++; if (n_hs != 384) begin errors++; $display("FAIL dflt_hsync got %0d exp 384", n_hs); end
    checks++; if (n_pix != 800) begin errors++; $display("FAIL dflt_ticks got %0d exp 800", n_pix); end
    checks++; if (n_ls != 1 || ls_at != 3200) begin errors++;
      $display("FAIL dflt_line got n=%0d at=%0d exp 1 3200", n_ls, ls_at); end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_pause();
    test_midreset();
    test_random_pause();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync logic feeding the game renderer in the top level.
- Sits between the 100 MHz board clock and the pixel/sprite renderer.
- Divides the clock to a pixel tick, runs horizontal/vertical counters, and decodes sync, active video, and line/frame markers.
- Adds pause (enable), programmable polarity, and a frame counter for game-physics timing.

Parameters:
CLK_DIV, 4, board clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level
CW, 10, hc/vc width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  board clock
clr  in  1  asynchronous active-high reset
en  in  1  1 = run; 0 = freeze all counters (pause)
pix_tick  out  1  one-clk strobe per pixel
hc  out  CW  horizontal pixel count, 0..H_TOTAL-1
vc  out  CW  vertical line count, 0..V_TOTAL-1
hsync  out  1  horizontal sync at HS_POL level
vsync  out  1  vertical sync at VS_POL level
active  out  1  1 when hc<H_ACTIVE and vc<V_ACTIVE
line_start  out  1  one-clk pulse when hc becomes 0
frame_start  out  1  one-clk pulse when hc and vc both become 0
frame_cnt  out  16  completed-frame counter

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (async, clr=1), all outputs consistent with position (0,0):
  - divider=0, hc=0, vc=0, pix_tick=0, line_start=0, frame_start=0, frame_cnt=0
  - hsync=~HS_POL, vsync=~VS_POL, active=1
- Divider: counts 0..CLK_DIV-1 while en=1.
  - pix_tick=1 in the clk where the divider holds CLK_DIV-1.
  - CLK_DIV=1: pix_tick=1 every clk while en=1.
- On each pix_tick clock edge: hc increments.
  - hc==H_TOTAL-1 wraps to 0 and increments vc.
  - vc==V_TOTAL-1 with hc wrap sends vc to 0.
- hsync, vsync, active, line_start, frame_start are registered.
  - They are computed from next-state counters, so they change in the same clk as hc/vc; zero lag relative to the counters.
- hsync asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
  - vsync changes only when hc changes to 0.
- line_start is high for exactly one clk after each hc wrap.
- frame_start coincides with the line_start that brings vc to 0.
  - frame_cnt increments in that same clk and wraps 65535->0.
- en=0:
  - divider, hc, vc, and frame_cnt hold.
  - pix_tick, line_start, frame_start forced 0.
  - Sync and active levels hold.
  - Re-enable resumes from the frozen divider value with no extra tick.
- Mid-frame reset returns to (0,0) immediately; no frame_start pulse is generated by reset.
- States: there is no separate FSM. Counter position defines the region: ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH, per axis.

Optional Feature:
- Macro: VGA_PIX_ADDR_EN.
- Defined: adds output pix_addr [19:0], the linear framebuffer address.
  - Resets to 0.
  - Increments by 1 on each pix_tick where active is 1 and hc<H_ACTIVE-1, or on the last active pixel of an active line.
  - Returns to 0 with frame_start.
  - Holds during blanking; no multiplier.
  - Value equals vc*H_ACTIVE+hc while active=1.
- Undefined: pix_addr port and logic absent; all other behaviour identical.

Test Plan:
- Small config (CLK_DIV=2; H 8/2/3/1, H_TOTAL=14; V 4/1/2/1, V_TOTAL=8):
  - Release clr -> pix_tick every 2nd clk.
  - hc sequence 0..13 then 0; line period 28 clk; frame_start every 224 clk.
  - frame_cnt=3 after 3 frames.
- Same config, hsync:
  - Asserted (0) exactly for hc=10..12 (6 clk).
  - vsync asserted for vc=5..6 (56 clk).
  - active=1 only for hc<8 and vc<4 (32 pixel ticks/frame).
- Polarity: HS_POL=1, VS_POL=1 -> sync levels inverted; reset values hsync=0, vsync=0.
- Pause: drop en at hc=5, vc=2 for 50 clk -> hc, vc, frame_cnt unchanged and no pix_tick.
  - After en=1, next pix_tick follows the frozen divider phase and hc resumes at 6.
- Reset mid-frame: assert clr at vc=6 -> hc=vc=0, frame_cnt=0, active=1, no frame_start pulse.
- Defaults (CLK_DIV=4, 640x480): hsync low 384 clk per 3200-clk line.
  - frame period 1,680,000 clk.
  - With VGA_PIX_ADDR_EN, pix_addr=307199 at hc=639, vc=479, then 0 at frame_start.
